seg7_alarm_display: RTL

Display and annunciation stage for the sensor warning board. It sits directly downstream of the UART sensor-frame receiver and consumes its four BCD digit nibbles and four warning flags. It time-multiplexes the digits onto a 4-digit common-anode 7-segment display with leading-zero blanking and anti-ghosting, and drives the status LEDs, the buzzer pattern and a blinking alarm display.

---
 rtl/seg7_alarm_display.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/seg7_alarm_display.sv
// seg7_alarm_display: 4-digit common-anode 7-segment scanner with
// leading-zero blanking and anti-ghost blanking, plus alarm annunciation.
// Ports: clk, rst_n (async, active-low); d3..d0 BCD digits (d3 = MSD);
//   temp/hum/smoke/esp32_warning flags; seg (active-low gfedcba),
//   dp (active-low, constant off), an (active-low, an[0] = d0),
//   led {esp32,smoke,hum,temp}, buzzer, alarm (OR of flags).
module seg7_alarm_display #(
    parameter int CLK_FREQ     = 40_000_000,
    parameter int REFRESH_HZ   = 250,
    parameter int BLANK_CYCLES = 64,
    parameter int BLINK_HZ     = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] d3,
    input  logic [3:0] d2,
    input  logic [3:0] d1,
    input  logic [3:0] d0,
    input  logic       temp,
    input  logic       hum,
    input  logic       smoke,
    input  logic       esp32_warning,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an,
    output logic [3:0] led,
    output logic       buzzer,
    output logic       alarm
);

    localparam int DP = CLK_FREQ / (4 * REFRESH_HZ);
    localparam int HP = CLK_FREQ / (2 * BLINK_HZ);
    localparam int DW = (DP > 1) ? $clog2(DP) : 1;
    localparam int HW = (HP > 1) ? $clog2(HP) : 1;

    localparam logic [DW-1:0] DP_LAST = DW'(DP - 1);
    localparam logic [DW-1:0] BLANK_N = DW'(BLANK_CYCLES);
    localparam logic [HW-1:0] HP_LAST = HW'(HP - 1);

    logic [DW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   snap_q, snap_d;
    logic [3:0]    flag_q;
    logic [HW-1:0] bcnt_q, bcnt_d;
    logic          phase_q, phase_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    led_q;
    logic          buzzer_q, buzzer_d;
    logic          alarm_q;

    logic          wrap;
    logic          alarm_w;
    logic [3:0]    cur;
    logic [3:0]    blank;
    logic          dark;

    function automatic logic [6:0] dec7(input logic [3:0] v);
        logic [6:0] r;
        case (v)
            4'd0:    r = 7'h40;
            4'd1:    r = 7'h79;
            4'd2:    r = 7'h24;
            4'd3:    r = 7'h30;
            4'd4:    r = 7'h19;
            4'd5:    r = 7'h12;
            4'd6:    r = 7'h02;
            4'd7:    r = 7'h78;
            4'd8:    r = 7'h00;
            4'd9:    r = 7'h10;
            default: r = 7'h3F;
        endcase
        return r;
    endfunction

    // Scan counter and digit index
    always_comb begin
        wrap  = (cnt_q == DP_LAST);
        cnt_d = wrap ? '0 : cnt_q + DW'(1);
        idx_d = wrap ? idx_q + 2'd1 : idx_q;
        // New digits enter only at a frame boundary
        snap_d = (wrap && idx_q == 2'd3) ? {d3, d2, d1, d0} : snap_q;
    end

    // Blink generator, held in the ON phase while no flag is present
    always_comb begin
        alarm_w = |flag_q;
        bcnt_d  = '0;
        phase_d = 1'b1;
        if (alarm_w) begin
            if (bcnt_q == HP_LAST) begin
                bcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                bcnt_d  = bcnt_q + HW'(1);
                phase_d = phase_q;
            end
        end
    end

    // Digit select and leading-zero blanking on the snapshot
    always_comb begin
        cur = 4'd0;
        case (idx_q)
            2'd0: cur = snap_q[3:0];
            2'd1: cur = snap_q[7:4];
            2'd2: cur = snap_q[11:8];
            2'd3: cur = snap_q[15:12];
            default: cur = 4'd0;
        endcase
        blank[3] = (snap_q[15:12] == 4'd0);
        blank[2] = blank[3] && (snap_q[11:8] == 4'd0);
        blank[1] = blank[2] && (snap_q[7:4] == 4'd0);
        blank[0] = 1'b0;
    end

    // Anode/segment drive; dark interval at the start of each digit
    // period keeps the previous digit from ghosting into the next one
    always_comb begin
        dark = (cnt_q < BLANK_N) || blank[idx_q] || (alarm_w && !phase_q);
        an_d  = dark ? 4'hF : ~(4'b0001 << idx_q);
        seg_d = dark ? 7'h7F : dec7(cur);
    end

    // Buzzer priority: smoke steady, temp/hum follow the blink
    always_comb begin
        buzzer_d = 1'b0;
        if (flag_q[2]) begin
            buzzer_d = 1'b1;
        end else if (flag_q[0] || flag_q[1]) begin
            buzzer_d = phase_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            idx_q    <= 2'd0;
            snap_q   <= 16'h0000;
            flag_q   <= 4'h0;
            bcnt_q   <= '0;
            phase_q  <= 1'b1;
            an_q     <= 4'hF;
            seg_q    <= 7'h7F;
            led_q    <= 4'h0;
            buzzer_q <= 1'b0;
            alarm_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            snap_q   <= snap_d;
            flag_q   <= {esp32_warning, smoke, hum, temp};
            bcnt_q   <= bcnt_d;
            phase_q  <= phase_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            led_q    <= flag_q;
            buzzer_q <= buzzer_d;
            alarm_q  <= alarm_w;
        end
    end

    assign seg    = seg_q;
    assign dp     = 1'b1;
    assign an     = an_q;
    assign led    = led_q;
    assign buzzer = buzzer_q;
    assign alarm  = alarm_q;

endmodule
